// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete with no added latency; misses walk WRITEBACK/FETCH/REFILL over a block handshake.
module dcache_ctrl #(
    parameter int LINES      = 16,
    parameter int BLOCK_BITS = 256,
    parameter int TAG_W      = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wr_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int WORDS  = BLOCK_BITS / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = $clog2(BLOCK_BITS / 8);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, REFILL} state_t;
    state_t state_reg, state_next;

    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [WSEL_W-1:0] cpu_word;
    logic              unused_addr_bits;

    assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
    assign cpu_idx          = cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_word         = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = &{1'b0, cpu_addr_i[1:0]};

    logic [LINES-1:0]      valid_reg, dirty_reg;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [BLOCK_BITS-1:0] data_mem [LINES];
    logic [BLOCK_BITS-1:0] block_buf_reg;

    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_BITS-1:0] line_data;
    logic [BLOCK_BITS-1:0] merged_line;
    logic [31:0]           line_words [WORDS];
    logic                  hit, store_hit, refill_we;

    assign line_tag  = tag_mem[cpu_idx];
    assign line_data = data_mem[cpu_idx];
    assign hit       = valid_reg[cpu_idx] && (line_tag == cpu_tag);

    // Split the selected line into words and build the store-merged copy.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = line_data[gi*32 +: 32];
            assign merged_line[gi*32 +: 32] =
                (cpu_word == WSEL_W'(gi)) ? cpu_data_i : line_words[gi];
        end
    endgenerate

    // Writes are masked during reset so an abandoned miss never touches a line.
    assign store_hit = rst_i && cpu_req_i && cpu_wr_i && hit && (state_reg == IDLE);
    assign refill_we = rst_i && (state_reg == REFILL);

    assign cpu_stall_o = cpu_req_i && (!hit || (state_reg != IDLE));
    assign cpu_data_o  = (cpu_req_i && hit) ? line_words[cpu_word] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    state_next = (valid_reg[cpu_idx] && dirty_reg[cpu_idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: if (mem_ack_i) state_next = FETCH;
            FETCH:     if (mem_ack_i) state_next = REFILL;
            REFILL:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = '0;
        case (state_reg)
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag, cpu_idx, {OFF_W{1'b0}}};
                mem_data_o   = line_data;
            end
            FETCH: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_reg     <= '0;
            dirty_reg     <= '0;
            block_buf_reg <= '0;
        end else begin
            if (refill_we) begin
                valid_reg[cpu_idx] <= 1'b1;
                dirty_reg[cpu_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_reg[cpu_idx] <= 1'b1;
            end
            if (state_reg == FETCH && mem_ack_i) begin
                block_buf_reg <= mem_data_i;
            end
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            data_mem[cpu_idx] <= block_buf_reg;
            tag_mem[cpu_idx]  <= cpu_tag;
        end else if (store_hit) begin
            data_mem[cpu_idx] <= merged_line;
        end
    end
endmodule
